// File: rtl/dm633_sequencer.sv
// rtl/dm633_sequencer.sv - framebuffer-to-DM633 serial frame sequencer
//
// Reads one frame from the framebuffer read port, highest address first,
// and shifts each word MSB first into the daisy-chained DM633 drivers.
// After the last word it pulses LAT and then reports completion.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start             one-cycle frame request (honoured only when idle)
//   o_busy, o_done      status: busy outside IDLE, one-cycle done pulse
//   o_ren, o_raddr      framebuffer read enable / address
//   i_rdata             framebuffer read data (one cycle after o_ren)
//   o_dck, o_dai, o_lat DM633 serial clock, serial data, latch
module dm633_sequencer #(
    parameter int c_ledboards  = 30,
    parameter int c_channels   = c_ledboards * 32,
    parameter int c_addr_w     = $clog2(c_channels),
    parameter int c_bps        = 12,
    parameter int c_clkdiv     = 2,
    parameter int c_lat_cycles = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_ren,
    output logic [c_addr_w-1:0] o_raddr,
    input  logic [c_bps-1:0]    i_rdata,
    output logic                o_dck,
    output logic                o_dai,
    output logic                o_lat
);

    localparam int c_div_w = (c_clkdiv > 1) ? $clog2(c_clkdiv) : 1;
    localparam int c_bit_w = (c_bps > 1) ? $clog2(c_bps) : 1;
    localparam int c_lat_w = (c_lat_cycles > 1) ? $clog2(c_lat_cycles) : 1;

    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(c_clkdiv - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(c_bps - 1);
    localparam logic [c_lat_w-1:0]  c_lat_last  = c_lat_w'(c_lat_cycles - 1);
    localparam logic [c_addr_w-1:0] c_addr_last = c_addr_w'(c_channels - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [c_bps-1:0]      sr_q, sr_d;
    logic [c_bps-1:0]      sr_shl;
    logic [c_div_w-1:0]    div_q, div_d;
    logic [c_bit_w-1:0]    bit_q, bit_d;
    logic [c_lat_w-1:0]    latc_q, latc_d;
    logic [c_addr_w-1:0]   raddr_q, raddr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ren_q, ren_d;
    logic                  dck_q, dck_d;
    logic                  dai_q, dai_d;
    logic                  lat_q, lat_d;

    // Every output is computed from the next state, so the registered
    // outputs line up exactly with the state they belong to.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        div_d   = div_q;
        bit_d   = bit_q;
        latc_d  = latc_q;
        raddr_d = raddr_q;
        done_d  = 1'b0;
        ren_d   = 1'b0;
        dck_d   = dck_q;
        dai_d   = dai_q;
        lat_d   = lat_q;
        sr_shl  = sr_q << 1;

        case (state_q)
            S_IDLE: begin
                dck_d = 1'b0;
                dai_d = 1'b0;
                lat_d = 1'b0;
                if (i_start) begin
                    state_d = S_FETCH;
                    raddr_d = c_addr_last;
                    ren_d   = 1'b1;
                end
            end

            S_FETCH: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                // Data arrives this cycle; present its MSB together with
                // the first low phase.
                state_d = S_SHIFT;
                sr_d    = i_rdata;
                dai_d   = i_rdata[c_bps-1];
                dck_d   = 1'b0;
                div_d   = c_div_last;
                bit_d   = c_bit_last;
            end

            S_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = c_div_last;
                    if (!dck_q) begin
                        dck_d = 1'b1;
                    end else begin
                        // End of a high phase: the bit has been clocked in.
                        dck_d = 1'b0;
                        sr_d  = sr_shl;
                        if (bit_q != '0) begin
                            bit_d = bit_q - 1'b1;
                            dai_d = sr_shl[c_bps-1];
                        end else if (raddr_q != '0) begin
                            // DAI keeps its last value through the gap.
                            state_d = S_FETCH;
                            raddr_d = raddr_q - 1'b1;
                            ren_d   = 1'b1;
                        end else begin
                            state_d = S_LATCH;
                            dai_d   = 1'b0;
                            lat_d   = 1'b1;
                            latc_d  = c_lat_last;
                        end
                    end
                end
            end

            S_LATCH: begin
                if (latc_q != '0) begin
                    latc_d = latc_q - 1'b1;
                end else begin
                    state_d = S_DONE;
                    lat_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            latc_q  <= '0;
            raddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ren_q   <= 1'b0;
            dck_q   <= 1'b0;
            dai_q   <= 1'b0;
            lat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            latc_q  <= latc_d;
            raddr_q <= raddr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ren_q   <= ren_d;
            dck_q   <= dck_d;
            dai_q   <= dai_d;
            lat_q   <= lat_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_ren   = ren_q;
    assign o_raddr = raddr_q;
    assign o_dck   = dck_q;
    assign o_dai   = dai_q;
    assign o_lat   = lat_q;

endmodule

// File: tb/tb_dm633_sequencer.sv
// tb/tb_dm633_sequencer.sv - self-checking bench for dm633_sequencer
module tb_dm633_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;

    logic        busy1, done1, ren1, dck1, dai1, lat1;
    logic [4:0]  raddr1;
    logic [11:0] rdata1 = '0;
    logic        busy2, done2, ren2, dck2, dai2, lat2;
    logic [4:0]  raddr2;
    logic [11:0] rdata2 = '0;

    logic [11:0] ram [32];

    int n_checks = 0;
    int n_errors = 0;

    // statistics collected by capture()
    int cyc_done, n_done, n_rise, n_lat, lat_pulses, n_ren, burst_bad;
    int setup_min, hold_min, high_bad, spacing_bad, dck_after_rst;
    int post_busy, post_ren, busy_after_done;
    logic [4:0] ren_addr [$];
    bit         bits [$];

    always #5 clk = ~clk;

    always @(posedge clk) if (ren1) rdata1 <= ram[raddr1];
    always @(posedge clk) if (ren2) rdata2 <= ram[raddr2];

    dm633_sequencer #(.c_ledboards(1), .c_bps(12), .c_clkdiv(1), .c_lat_cycles(4)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .o_busy(busy1), .o_done(done1),
        .o_ren(ren1), .o_raddr(raddr1), .i_rdata(rdata1),
        .o_dck(dck1), .o_dai(dai1), .o_lat(lat1)
    );

    dm633_sequencer #(.c_ledboards(1), .c_bps(12), .c_clkdiv(2), .c_lat_cycles(4)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .o_busy(busy2), .o_done(done2),
        .o_ren(ren2), .o_raddr(raddr2), .i_rdata(rdata2),
        .o_dck(dck2), .o_dai(dai2), .o_lat(lat2)
    );

    // Reference stream: address 31 first, MSB first within each word.
    function automatic int count_bit_errs();
        int errs = 0;
        for (int k = 0; k < 384; k++) begin
            if (k >= bits.size()) errs++;
            else if (bits[k] != ram[31 - k / 12][11 - k % 12]) errs++;
        end
        return errs;
    endfunction

    // Starts one frame on the selected DUT and records what the pins do.
    // Cycle 1 is the first cycle after the edge that sampled i_start.
    task automatic capture(input bit use2, input int div, input int extra_start,
                           input bit start_in_done, input int rst_cyc, input int budget);
        int cyc, cur_burst, last_rise, last_chg, high_len;
        logic p_dck, p_dai, p_lat;
        logic s_dck, s_dai, s_lat, s_ren, s_done, s_busy;
        logic [4:0] s_raddr;
        bit go, v;
        cyc_done = -1; n_done = 0; n_rise = 0; n_lat = 0; lat_pulses = 0; n_ren = 0;
        burst_bad = 0; setup_min = 1000; hold_min = 1000; high_bad = 0; spacing_bad = 0;
        dck_after_rst = 0; post_busy = 0; post_ren = 0; busy_after_done = -1;
        ren_addr.delete(); bits.delete();
        cur_burst = 0; last_rise = -1000; last_chg = 0; high_len = 0;
        p_dck = 1'b0; p_dai = 1'b0; p_lat = 1'b0;
        @(negedge clk);
        if (use2) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        cyc = 1;
        go = 1'b1;
        while (go) begin
            s_dck   = use2 ? dck2 : dck1;
            s_dai   = use2 ? dai2 : dai1;
            s_lat   = use2 ? lat2 : lat1;
            s_ren   = use2 ? ren2 : ren1;
            s_done  = use2 ? done2 : done1;
            s_busy  = use2 ? busy2 : busy1;
            s_raddr = use2 ? raddr2 : raddr1;
            if (s_ren) begin
                if (n_ren > 0 && cur_burst != 12) burst_bad++;
                cur_burst = 0;
                n_ren++;
                ren_addr.push_back(s_raddr);
            end
            if (s_dai !== p_dai) begin
                if (cyc - last_rise < hold_min) hold_min = cyc - last_rise;
                last_chg = cyc;
            end
            if (s_dck && !p_dck) begin
                if (cur_burst > 0 && cyc - last_rise != 2 * div) spacing_bad++;
                if (cyc - last_chg < setup_min) setup_min = cyc - last_chg;
                bits.push_back(s_dai);
                n_rise++;
                cur_burst++;
                last_rise = cyc;
                high_len = 0;
            end
            if (s_dck) high_len++;
            else if (p_dck && high_len != div) high_bad++;
            if (s_lat) begin
                n_lat++;
                if (!p_lat) begin
                    lat_pulses++;
                    if (cur_burst != 12) burst_bad++;
                end
            end
            if (s_done) begin
                n_done++;
                if (cyc_done < 0) cyc_done = cyc;
            end
            if (cyc_done > 0 && cyc > cyc_done) begin
                if (s_busy) post_busy++;
                if (s_ren) post_ren++;
                if (cyc == cyc_done + 1) busy_after_done = int'(s_busy);
            end
            if (rst_cyc > 0 && cyc > rst_cyc && s_dck) dck_after_rst++;
            p_dck = s_dck; p_dai = s_dai; p_lat = s_lat;
            v = (cyc == extra_start) || (start_in_done && s_done);
            if (use2) start2 = v; else start1 = v;
            if (rst_cyc > 0 && cyc == rst_cyc) rst = 1'b1;
            if (rst_cyc > 0 && cyc == rst_cyc + 2) rst = 1'b0;
            if (cyc >= budget || (cyc_done > 0 && cyc >= cyc_done + 30)) go = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic test_reset();
        int act;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy1, busy2, ren1, dck1, lat1, done1} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_release: outputs=%b required 000000", {busy1, busy2, ren1, dck1, lat1, done1});
        end
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_prebusy: busy=%b required 1", busy1);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy1, done1, ren1, raddr1, dck1, dai1, lat1} !== 11'b0) begin
            n_errors++;
            $display("FAIL reset_async: outputs=%b required 0", {busy1, done1, ren1, raddr1, dck1, dai1, lat1});
        end
        @(negedge clk);
        rst = 1'b0;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy1 || ren1 || dck1 || lat1 || busy2 || ren2 || dck2 || lat2) act++;
        end
        n_checks++;
        if (act != 0) begin
            n_errors++;
            $display("FAIL reset_idle: active cycles=%0d required 0", act);
        end
    endtask

    task automatic test_single_frame();
        logic [11:0] w0, w1;
        int errs;
        for (int a = 0; a < 32; a++) ram[a] = 12'h000;
        ram[31] = 12'hC00;
        ram[30] = 12'h001;
        capture(1'b0, 1, 0, 1'b0, 0, 1000);
        w0 = '0; w1 = '0;
        for (int i = 0; i < 12 && i < bits.size(); i++) w0 = {w0[10:0], bits[i]};
        for (int i = 12; i < 24 && i < bits.size(); i++) w1 = {w1[10:0], bits[i]};
        n_checks++;
        if (w0 !== 12'b1100_0000_0000) begin
            n_errors++;
            $display("FAIL single_word0: got %h required c00", w0);
        end
        n_checks++;
        if (w1 !== 12'b0000_0000_0001) begin
            n_errors++;
            $display("FAIL single_word1: got %h required 001", w1);
        end
        n_checks++;
        if (n_rise != 384) begin
            n_errors++;
            $display("FAIL single_rises: got %0d required 384", n_rise);
        end
        n_checks++;
        if (n_lat != 4 || lat_pulses != 1) begin
            n_errors++;
            $display("FAIL single_lat: high cycles=%0d pulses=%0d required 4/1", n_lat, lat_pulses);
        end
        n_checks++;
        if (cyc_done != 837 || n_done != 1) begin
            n_errors++;
            $display("FAIL single_done: cycle=%0d count=%0d required 837/1", cyc_done, n_done);
        end
        errs = count_bit_errs();
        n_checks++;
        if (errs != 0) begin
            n_errors++;
            $display("FAIL single_stream: bit errors=%0d required 0", errs);
        end
    endtask

    task automatic test_address_sequence();
        int bad, errs;
        for (int a = 0; a < 32; a++) ram[a] = 12'((a * 12'h0A5) ^ 12'h5C3);
        capture(1'b0, 1, 0, 1'b0, 0, 1000);
        n_checks++;
        if (n_ren != 32) begin
            n_errors++;
            $display("FAIL addr_count: ren pulses=%0d required 32", n_ren);
        end
        bad = 0;
        for (int i = 0; i < ren_addr.size(); i++) if (ren_addr[i] !== 5'(31 - i)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL addr_order: wrong addresses=%0d required 0", bad);
        end
        n_checks++;
        if (burst_bad != 0) begin
            n_errors++;
            $display("FAIL addr_burst: bad bursts=%0d required 0", burst_bad);
        end
        errs = count_bit_errs();
        n_checks++;
        if (errs != 0 || cyc_done != 837) begin
            n_errors++;
            $display("FAIL addr_stream: bit errors=%0d done=%0d required 0/837", errs, cyc_done);
        end
    endtask

    task automatic test_start_while_busy();
        capture(1'b0, 1, 100, 1'b1, 0, 1000);
        n_checks++;
        if (n_done != 1 || cyc_done != 837 || n_ren != 32) begin
            n_errors++;
            $display("FAIL busy_frame: done=%0d at %0d ren=%0d required 1/837/32", n_done, cyc_done, n_ren);
        end
        n_checks++;
        if (busy_after_done != 0 || post_busy != 0 || post_ren != 0) begin
            n_errors++;
            $display("FAIL busy_after: busy=%0d post_busy=%0d post_ren=%0d required 0/0/0",
                     busy_after_done, post_busy, post_ren);
        end
    endtask

    task automatic test_reset_mid_shift();
        int errs;
        for (int a = 0; a < 32; a++) ram[a] = 12'hFFF - 12'(a);
        capture(1'b0, 1, 0, 1'b0, 300, 900);
        n_checks++;
        if (n_lat != 0 || n_done != 0 || dck_after_rst != 0) begin
            n_errors++;
            $display("FAIL midrst_quiet: lat=%0d done=%0d dck=%0d required 0/0/0", n_lat, n_done, dck_after_rst);
        end
        capture(1'b0, 1, 0, 1'b0, 0, 1000);
        errs = count_bit_errs();
        n_checks++;
        if (cyc_done != 837 || errs != 0 || n_lat != 4 || n_ren != 32) begin
            n_errors++;
            $display("FAIL midrst_refill: done=%0d errs=%0d lat=%0d ren=%0d required 837/0/4/32",
                     cyc_done, errs, n_lat, n_ren);
        end
    endtask

    task automatic test_clkdiv2();
        int errs;
        for (int a = 0; a < 32; a++) ram[a] = 12'((a * 12'h3B7) ^ 12'hA5A);
        capture(1'b1, 2, 0, 1'b0, 0, 1700);
        n_checks++;
        if (cyc_done != 1605) begin
            n_errors++;
            $display("FAIL div2_done: cycle=%0d required 1605", cyc_done);
        end
        n_checks++;
        if (high_bad != 0 || spacing_bad != 0) begin
            n_errors++;
            $display("FAIL div2_phase: bad high=%0d bad spacing=%0d required 0/0", high_bad, spacing_bad);
        end
        n_checks++;
        if (setup_min < 2 || hold_min < 2) begin
            n_errors++;
            $display("FAIL div2_setup_hold: setup=%0d hold=%0d required >=2", setup_min, hold_min);
        end
        errs = count_bit_errs();
        n_checks++;
        if (errs != 0 || n_rise != 384 || n_lat != 4) begin
            n_errors++;
            $display("FAIL div2_stream: errs=%0d rises=%0d lat=%0d required 0/384/4", errs, n_rise, n_lat);
        end
    endtask

    initial begin
        for (int a = 0; a < 32; a++) ram[a] = 12'h000;
        test_reset();
        test_single_frame();
        test_address_sequence();
        test_start_while_busy();
        test_reset_mid_shift();
        test_clkdiv2();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dm633_sequencer.md
Name: dm633_sequencer

Overview:
- Reads one complete frame out of the framebuffer over its synchronous read port and shifts it serially into the daisy-chained DM633 drivers (DAI/DCK), then pulses LAT so the drivers take the new frame.
- Sits between the framebuffer read port and the ledboard connector pins.
- One frame per i_start request. The framebuffer write side is not touched.

Parameters:
- c_ledboards, 30, number of ledboards in the chain.
- c_channels, c_ledboards*32, total PWM channels (two DM633 per board).
- c_addr_w, $clog2(c_channels), framebuffer address width.
- c_bps, 12, bits per channel.
- c_clkdiv, 2, DCK half-period in i_clk cycles; legal range ≥1.
- c_lat_cycles, 4, LAT high time in i_clk cycles; legal range ≥1.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_start  in  1  one-cycle request to send a frame; honoured only in IDLE.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the frame has been latched.
- o_ren  out  1  framebuffer read enable.
- o_raddr  out  c_addr_w  framebuffer read address.
- i_rdata  in  c_bps  framebuffer read data, valid the cycle after o_ren.
- o_dck  out  1  DM633 serial clock; drivers sample DAI on the rising edge.
- o_dai  out  1  DM633 serial data.
- o_lat  out  1  DM633 latch.

Behaviour:
- All outputs are registered.
- i_rst asserted → immediately: state IDLE, all outputs 0, o_raddr 0, shift register and counters 0.
- Reset mid-frame never asserts o_lat, so the drivers keep the previously latched frame.
- States: IDLE → FETCH → LOAD → SHIFT → (FETCH | LATCH) → DONE → IDLE.
- IDLE:
  - o_dck, o_dai, o_lat, o_ren all 0.
  - i_start=1 → FETCH, word address = c_channels-1.
- FETCH (1 cycle): o_ren=1, o_raddr = word address.
- LOAD (1 cycle): o_ren=0; shift register ← i_rdata at the closing edge; bit counter = c_bps-1.
- SHIFT, per bit, MSB first:
  - Low phase: o_dai = current MSB, o_dck=0 for c_clkdiv cycles.
  - High phase: o_dck=1 for c_clkdiv cycles.
  - Then shift left by one.
  - o_dai only changes at the start of a low phase (setup and hold ≥ c_clkdiv cycles around the rising edge).
- After the last bit's high phase:
  - Word address ≠ 0 → decrement the address, go to FETCH.
  - Word address = 0 → go to LATCH.
  - o_dck=0 and o_dai holds its last value during FETCH/LOAD gaps.
- Order: the highest address is shifted first, so after a full frame address 0 sits in the chain position nearest the DAI input's far end (the first driver output).
- LATCH: o_lat=1 for c_lat_cycles cycles; o_dck=0, o_dai=0.
- DONE (1 cycle): o_done=1, o_lat=0 → IDLE.
- Cycle accounting:
  - Per word: 2 + 2·c_bps·c_clkdiv cycles.
  - Frame: c_channels·(2+2·c_bps·c_clkdiv) + c_lat_cycles + 1 cycles from the first FETCH to the end of DONE.
- i_start in any state other than IDLE (including DONE) is ignored; it is not queued.
- Exactly one o_ren pulse per channel per frame. o_raddr is held between fetches.
- Counters are sized from parameters; no wrap beyond address 0.

Test Plan:
- Bench setup: c_ledboards=1 (32 channels), c_clkdiv=1, c_lat_cycles=4, behavioural 1-cycle-latency RAM model.
- Reset: assert i_rst asynchronously mid-cycle → all outputs 0 before the next edge; after release o_busy=0, no activity without i_start.
- Single frame:
  - RAM[31]=12'hC00, RAM[30]=12'h001, others 12'h000; pulse i_start.
  - First 12 bits sampled on DCK rising edges = 1100_0000_0000, next 12 = 0000_0000_0001.
  - 384 rising edges total before LAT.
  - o_lat high exactly 4 cycles.
  - o_done in cycle 837 after the start-sampling edge (FETCH = cycle 1).
- Address sequence: log o_ren pulses → 32 pulses, o_raddr 31,30,…,0, each followed by a rising-edge bit burst of exactly 12.
- Start while busy: pulse i_start at cycle 100 and in the DONE cycle → no second frame; o_busy low the cycle after DONE.
- Reset mid-shift: assert i_rst at cycle 300 → o_lat never pulses, o_dck=0; a new i_start afterwards produces a complete, correct 837-cycle frame.
- c_clkdiv=2 rerun: DCK high and low phases are each 2 cycles; o_dai stable for 2 cycles either side of each rising edge; o_done at cycle 32·50+4+1=1605.
